// File: rtl/pwm_duty_decoder.sv
// Receive side of the PWM link: measures the period and high time of salida_i in clock
// cycles and recovers the 0..10 duty setting with a ten-step repeated-addition divider.
module pwm_duty_decoder #(
    parameter int CW      = 20,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic          CLKNEXYS,
    input  logic          MRst,
    input  logic          En_i,
    input  logic          salida_i,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] high_o,
    output logic [3:0]    duty_o,
    output logic          valid_o,
    output logic          no_signal_o,
    output logic          overrun_o
);
    localparam int            TW        = CW + 4;
    localparam logic [CW-1:0] TO_CNT    = CW'(TIMEOUT);
    localparam logic [3:0]    DIV_STEPS = 4'd10;

    typedef enum logic [1:0] {SEEK, HIGH, LOW} meas_state_t;
    typedef enum logic       {DIV_IDLE, DIV_RUN} div_state_t;

    meas_state_t   meas_q, meas_d;
    div_state_t    div_q, div_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d, hi_lat_q, hi_lat_d;
    logic [CW-1:0] dper_q, dper_d, dhi_q, dhi_d;
    logic [TW-1:0] tgt_q, tgt_d, acc_q, acc_d;
    logic [3:0]    k_q, k_d, step_q, step_d;
    logic [CW-1:0] period_q, period_d, high_q, high_d;
    logic [3:0]    duty_q, duty_d;
    logic          valid_q, valid_d, nosig_q, nosig_d, overrun_q, overrun_d;
    logic          rise, fall, timed_out, start, timeout;
    logic [TW:0]   acc_next;

    // Adding half a period before the division turns truncation into round-to-nearest.
    function automatic logic [TW-1:0] round_target(input logic [CW-1:0] hi,
                                                   input logic [CW-1:0] per);
        return TW'(hi) * TW'(10) + TW'(per >> 1);
    endfunction

    function automatic logic [3:0] saturate_duty(input logic [3:0] k);
        return (k > 4'd10) ? 4'd10 : k;
    endfunction

    always_comb begin
        sync1_d   = salida_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        rise      = sync2_q & ~prev_q;
        fall      = ~sync2_q & prev_q;
        timed_out = (cnt_q >= TO_CNT);
        acc_next  = {1'b0, acc_q} + (TW+1)'(dper_q);

        meas_d    = meas_q;
        cnt_d     = cnt_q;
        hi_lat_d  = hi_lat_q;
        div_d     = div_q;
        dper_d    = dper_q;
        dhi_d     = dhi_q;
        tgt_d     = tgt_q;
        acc_d     = acc_q;
        k_d       = k_q;
        step_d    = step_q;
        period_d  = period_q;
        high_d    = high_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        nosig_d   = nosig_q;
        overrun_d = overrun_q;
        start     = 1'b0;
        timeout   = 1'b0;

        if (!En_i) begin
            meas_d = SEEK;
            cnt_d  = '0;
        end else begin
            case (meas_q)
                SEEK: begin
                    if (rise) begin
                        cnt_d  = CW'(1);
                        meas_d = HIGH;
                    end else if (timed_out) begin
                        timeout = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_lat_d = cnt_q;
                        cnt_d    = cnt_q + CW'(1);
                        meas_d   = LOW;
                    end else if (timed_out) begin
                        timeout = 1'b1;
                        cnt_d   = '0;
                        meas_d  = SEEK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                LOW: begin
                    if (rise) begin
                        start  = 1'b1;
                        cnt_d  = CW'(1);
                        meas_d = HIGH;
                    end else if (timed_out) begin
                        timeout = 1'b1;
                        cnt_d   = '0;
                        meas_d  = SEEK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: meas_d = SEEK;
            endcase
        end

        // The divider always takes the full ten steps so its busy window, and hence the
        // shortest period that avoids overrun, does not depend on the duty value.
        case (div_q)
            DIV_IDLE: begin
                if (start) begin
                    tgt_d  = round_target(hi_lat_q, cnt_q);
                    dper_d = cnt_q;
                    dhi_d  = hi_lat_q;
                    acc_d  = '0;
                    k_d    = '0;
                    step_d = '0;
                    div_d  = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (start) overrun_d = 1'b1;
                if (step_q == DIV_STEPS) begin
                    duty_d   = saturate_duty(k_q);
                    period_d = dper_q;
                    high_d   = dhi_q;
                    nosig_d  = 1'b0;
                    valid_d  = 1'b1;
                    div_d    = DIV_IDLE;
                end else begin
                    step_d = step_q + 4'd1;
                    if (k_q < 4'd10 && acc_next <= {1'b0, tgt_q}) begin
                        acc_d = acc_next[TW-1:0];
                        k_d   = k_q + 4'd1;
                    end
                end
            end
            default: div_d = DIV_IDLE;
        endcase

        if (timeout) begin
            nosig_d  = 1'b1;
            period_d = '0;
            high_d   = '0;
            duty_d   = sync2_q ? 4'd10 : 4'd0;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge CLKNEXYS) begin
        if (MRst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            meas_q    <= SEEK;
            div_q     <= DIV_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            nosig_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            meas_q    <= meas_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            nosig_q   <= nosig_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge CLKNEXYS) begin
        hi_lat_q <= hi_lat_d;
        dper_q   <= dper_d;
        dhi_q    <= dhi_d;
        tgt_q    <= tgt_d;
        acc_q    <= acc_d;
        k_q      <= k_d;
        step_q   <= step_d;
    end

    assign period_o    = period_q;
    assign high_o      = high_q;
    assign duty_o      = duty_q;
    assign valid_o     = valid_q;
    assign no_signal_o = nosig_q;
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized bench for pwm_duty_decoder; a period-level model predicts every valid_o update.
module tb_pwm_duty_decoder;
    localparam int CW = 20;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          rst, en, sal;
    logic [CW-1:0] period_o, high_o;
    logic [3:0]    duty_o;
    logic          valid_o, no_signal_o, overrun_o;

    typedef struct packed {
        logic [CW-1:0] per;
        logic [CW-1:0] hi;
        logic [3:0]    duty;
        logic          ns;
    } meas_t;

    meas_t obs_q[$];
    meas_t exp_q[$];
    int    nvec = 0;
    int    nfail = 0;
    bit    armed = 1'b0;
    int    last_p, last_h;

    pwm_duty_decoder #(.CW(CW), .TIMEOUT(TO)) dut (
        .CLKNEXYS(clk), .MRst(rst), .En_i(en), .salida_i(sal),
        .period_o(period_o), .high_o(high_o), .duty_o(duty_o),
        .valid_o(valid_o), .no_signal_o(no_signal_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (valid_o === 1'b1) obs_q.push_back({period_o, high_o, duty_o, no_signal_o});

    function automatic meas_t ref_meas(int p, int h);
        int d;
        d = (10 * h + p / 2) / p;
        if (d > 10) d = 10;
        return {CW'(p), CW'(h), 4'(d), 1'b0};
    endfunction

    function automatic meas_t timeout_meas(bit lvl);
        return {CW'(0), CW'(0), lvl ? 4'd10 : 4'd0, 1'b1};
    endfunction

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resync();
        @(negedge clk);
        en  = 1'b0;
        sal = 1'b0;
        cycles(5);
        en = 1'b1;
        cycles(2);
        armed = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    // Each rise closes the previous period, so that is where the model emits its record.
    task automatic drive_period(int p, int h);
        if (armed) exp_q.push_back(ref_meas(last_p, last_h));
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            sal = (i < h);
        end
        armed  = 1'b1;
        last_p = p;
        last_h = h;
    endtask

    task automatic hold_high_timeout();
        if (armed) exp_q.push_back(ref_meas(last_p, last_h));
        @(negedge clk);
        sal = 1'b1;
        cycles(TO + 100);
        exp_q.push_back(timeout_meas(1'b1));
        armed = 1'b0;
    endtask

    task automatic hold_low_timeout();
        @(negedge clk);
        sal = 1'b0;
        cycles(TO + 100);
        exp_q.push_back(timeout_meas(1'b0));
        armed = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        sal = 1'b0;
        cycles(3);
        nvec++; if (period_o !== '0)    begin nfail++; $display("FAIL reset_period: got %0d want 0", period_o); end
        nvec++; if (high_o !== '0)      begin nfail++; $display("FAIL reset_high: got %0d want 0", high_o); end
        nvec++; if (duty_o !== 4'd0)    begin nfail++; $display("FAIL reset_duty: got %0d want 0", duty_o); end
        nvec++; if (valid_o !== 1'b0)   begin nfail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        nvec++; if (no_signal_o !== 1'b0) begin nfail++; $display("FAIL reset_nosig: got %b want 0", no_signal_o); end
        nvec++; if (overrun_o !== 1'b0) begin nfail++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_basic();
        resync();
        for (int i = 0; i < 5; i++) drive_period(100, 30);
        cycles(20);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL basic_meas[%0d]: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, obs_q[i].ns,
                         exp_q[i].per, exp_q[i].hi, exp_q[i].duty, exp_q[i].ns);
            end
        end
        nvec++; if (overrun_o !== 1'b0) begin nfail++; $display("FAIL basic_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_rounding_timeout();
        resync();
        for (int i = 0; i < 3; i++) drive_period(100, 35);
        for (int i = 0; i < 3; i++) drive_period(100, 34);
        hold_high_timeout();
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL round_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL round_meas[%0d]: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, obs_q[i].ns,
                         exp_q[i].per, exp_q[i].hi, exp_q[i].duty, exp_q[i].ns);
            end
        end
        nvec++; if (no_signal_o !== 1'b1) begin nfail++; $display("FAIL stuck_high_nosig: got %b want 1", no_signal_o); end
        nvec++; if (duty_o !== 4'd10)     begin nfail++; $display("FAIL stuck_high_duty: got %0d want 10", duty_o); end
    endtask

    task automatic test_low_timeout();
        resync();
        hold_low_timeout();
        for (int i = 0; i < 3; i++) drive_period(200, 100);
        cycles(20);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL low_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL low_meas[%0d]: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, obs_q[i].ns,
                         exp_q[i].per, exp_q[i].hi, exp_q[i].duty, exp_q[i].ns);
            end
        end
        nvec++; if (no_signal_o !== 1'b0) begin nfail++; $display("FAIL low_recover_nosig: got %b want 0", no_signal_o); end
    endtask

    task automatic test_misb_loop();
        int refs[6] = '{2, 3, 5, 7, 8, 10};
        int m;
        resync();
        foreach (refs[r]) begin
            if (refs[r] == 10) begin
                hold_high_timeout();
            end else begin
                m = $urandom_range(10, 25);
                for (int i = 0; i < 3; i++) drive_period(10 * m, refs[r] * m);
            end
        end
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL misb_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL misb_meas[%0d]: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, obs_q[i].ns,
                         exp_q[i].per, exp_q[i].hi, exp_q[i].duty, exp_q[i].ns);
            end
        end
    endtask

    task automatic test_random();
        int p, h;
        resync();
        for (int i = 0; i < 14; i++) begin
            p = $urandom_range(20, 300);
            h = $urandom_range(1, p - 1);
            drive_period(p, h);
        end
        cycles(20);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL rand_meas[%0d]: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, obs_q[i].ns,
                         exp_q[i].per, exp_q[i].hi, exp_q[i].duty, exp_q[i].ns);
            end
        end
    endtask

    task automatic test_enable_freeze();
        meas_t held, cur;
        resync();
        for (int i = 0; i < 3; i++) drive_period(100, 60);
        cycles(20);
        held = ref_meas(100, 60);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            sal = ((i % 100) < 20);
        end
        cur = {period_o, high_o, duty_o, no_signal_o};
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL en_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        nvec++;
        if (cur !== held) begin
            nfail++;
            $display("FAIL en_frozen: got p=%0d h=%0d d=%0d ns=%0d want p=%0d h=%0d d=%0d ns=%0d",
                     cur.per, cur.hi, cur.duty, cur.ns, held.per, held.hi, held.duty, held.ns);
        end
        en = 1'b1;
        armed = 1'b0;
    endtask

    task automatic test_overrun();
        meas_t want;
        resync();
        nvec++; if (overrun_o !== 1'b0) begin nfail++; $display("FAIL ovr_before: got %b want 0", overrun_o); end
        for (int i = 0; i < 10; i++) drive_period(8, 4);
        cycles(20);
        want = ref_meas(8, 4);
        nvec++; if (overrun_o !== 1'b1) begin nfail++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
        nvec++; if (obs_q.size() != 5) begin nfail++; $display("FAIL ovr_count: got %0d want 5", obs_q.size()); end
        foreach (obs_q[i]) begin
            nvec++;
            if (obs_q[i] !== want) begin
                nfail++;
                $display("FAIL ovr_meas[%0d]: got p=%0d h=%0d d=%0d want p=8 h=4 d=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, want.duty);
            end
        end
        for (int i = 0; i < 2; i++) drive_period(100, 30);
        nvec++; if (overrun_o !== 1'b1) begin nfail++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
    endtask

    task automatic test_mrst();
        resync();
        for (int i = 0; i < 2; i++) drive_period(100, 30);
        @(negedge clk);
        sal = 1'b1;
        cycles(50);
        rst = 1'b1;
        sal = 1'b0;
        @(negedge clk);
        nvec++; if (period_o !== '0)      begin nfail++; $display("FAIL mrst_period: got %0d want 0", period_o); end
        nvec++; if (high_o !== '0)        begin nfail++; $display("FAIL mrst_high: got %0d want 0", high_o); end
        nvec++; if (duty_o !== 4'd0)      begin nfail++; $display("FAIL mrst_duty: got %0d want 0", duty_o); end
        nvec++; if (overrun_o !== 1'b0)   begin nfail++; $display("FAIL mrst_overrun: got %b want 0", overrun_o); end
        nvec++; if (no_signal_o !== 1'b0) begin nfail++; $display("FAIL mrst_nosig: got %b want 0", no_signal_o); end
        rst = 1'b0;
        armed = 1'b0;
        obs_q.delete();
        exp_q.delete();
        cycles(3);
        drive_period(100, 30);
        nvec++; if (obs_q.size() != 0) begin nfail++; $display("FAIL mrst_early_valid: got %0d want 0", obs_q.size()); end
        drive_period(100, 30);
        cycles(20);
        nvec++;
        if (obs_q.size() != exp_q.size()) begin
            nfail++; $display("FAIL mrst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            nvec++;
            if (obs_q[i] !== exp_q[i]) begin
                nfail++;
                $display("FAIL mrst_meas[%0d]: got p=%0d h=%0d d=%0d want p=%0d h=%0d d=%0d", i,
                         obs_q[i].per, obs_q[i].hi, obs_q[i].duty, exp_q[i].per, exp_q[i].hi, exp_q[i].duty);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sal = 1'b0;
        test_reset();
        test_basic();
        test_rounding_timeout();
        test_low_timeout();
        test_misb_loop();
        test_random();
        test_enable_freeze();
        test_overrun();
        test_mrst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
